sync_tx: RTL

Serial K/J line transmitter: the transmit-side counterpart of the sync-detecting receiver (`circuito12`), which consumes `k`, `j` and `rx_en`. It frames bytes into packets: an 8-symbol SYNC pattern, NRZI-encoded LSB-first payload with bit stuffing, then an EOP. Its `k`/`j`/`tx_en` outputs connect directly to the receiver's `k`/`j`/`rx_en`, either in a loopback bench or as a functional stimulus source beside the BIST path.

---
 rtl/sync_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sync_tx.sv
// rtl/sync_tx.sv - K/J line transmitter: SYNC, NRZI payload with bit stuffing, EOP
module sync_tx #(
    parameter int STUFF_RUN = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       k,
    output logic       j,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int OW = $clog2(STUFF_RUN + 1);
    localparam logic [OW-1:0] RUN    = OW'(STUFF_RUN);
    localparam logic [OW-1:0] RUN_M1 = OW'(STUFF_RUN - 1);
    // bit n is 1 where SYNC symbol n is K: K J K J K J K K
    localparam logic [7:0] SYNC_K = 8'b1101_0101;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          tail, tail_n;
    logic [OW-1:0] ones, ones_n;
    logic          last_q, last_n;
    logic          k_n, j_n, en_n, done_n, under_n;
    logic          stuff, last_sym;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        tail_n    = tail;
        ones_n    = ones;
        last_n    = last_q;
        k_n       = k;
        j_n       = j;
        en_n      = tx_en;
        done_n    = 1'b0;
        under_n   = 1'b0;
        tx_ready  = 1'b0;
        stuff     = 1'b0;
        last_sym  = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                k_n      = 1'b0;
                j_n      = 1'b1;
                en_n     = 1'b0;
                if (tx_valid) begin
                    shreg_n = tx_data;
                    last_n  = tx_last;
                    cnt_n   = 3'd0;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                en_n  = 1'b1;
                k_n   = SYNC_K[cnt];
                j_n   = ~SYNC_K[cnt];
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    ones_n    = '0;
                    bit_idx_n = 3'd0;
                    tail_n    = 1'b0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                en_n  = 1'b1;
                stuff = (ones == RUN);
                if (stuff) begin
                    k_n      = ~k;
                    j_n      = ~j;
                    ones_n   = '0;
                    tail_n   = 1'b0;
                    last_sym = tail;
                end else begin
                    if (shreg[0]) begin
                        ones_n = ones + 1'b1;
                    end else begin
                        k_n    = ~k;
                        j_n    = ~j;
                        ones_n = '0;
                    end
                    shreg_n   = {1'b0, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    // a 1 that completes a run defers the byte end to the stuff bit
                    if (bit_idx == 3'd7) begin
                        if (shreg[0] && ones == RUN_M1) tail_n = 1'b1;
                        else                            last_sym = 1'b1;
                    end
                end
                if (last_sym) begin
                    if (last_q) begin
                        cnt_n   = 3'd0;
                        state_n = EOP;
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            shreg_n   = tx_data;
                            last_n    = tx_last;
                            bit_idx_n = 3'd0;
                        end else begin
                            under_n = 1'b1;
                            cnt_n   = 3'd0;
                            state_n = EOP;
                        end
                    end
                end
            end
            EOP: begin
                en_n  = 1'b1;
                cnt_n = cnt + 3'd1;
                case (cnt)
                    3'd0, 3'd1: begin
                        k_n = 1'b0;
                        j_n = 1'b0;
                    end
                    3'd2: begin
                        k_n = 1'b0;
                        j_n = 1'b1;
                    end
                    default: begin
                        k_n     = 1'b0;
                        j_n     = 1'b1;
                        en_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            tail     <= 1'b0;
            ones     <= '0;
            last_q   <= 1'b0;
            k        <= 1'b0;
            j        <= 1'b1;
            tx_en    <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            tail     <= tail_n;
            ones     <= ones_n;
            last_q   <= last_n;
            k        <= k_n;
            j        <= j_n;
            tx_en    <= en_n;
            done     <= done_n;
            underrun <= under_n;
        end
    end

    assign busy = (state != IDLE);
endmodule
